// File: rtl/ctrl_pkg.sv
// Shared encodings for the control unit: opcodes, ALU operation codes,
// the FSM state enumeration and the packed control-signal bundle.
package ctrl_pkg;

    // Instruction opcodes (IR[31:27])
    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    // ALU operation codes share the opcode numbering of the ALU instructions
    localparam logic [4:0] ALU_ADD = 5'd3;
    localparam logic [4:0] ALU_SUB = 5'd4;
    localparam logic [4:0] ALU_AND = 5'd5;
    localparam logic [4:0] ALU_OR  = 5'd6;
    localparam logic [4:0] ALU_MUL = 5'd15;
    localparam logic [4:0] ALU_DIV = 5'd16;

    // One state per control step; execute steps are shared where the
    // micro-operations are identical and split later on the latched opcode.
    typedef enum logic [4:0] {
        S_RESET,
        S_T0, S_T1, S_T2,
        S_ALU_T3, S_ALU_T4, S_ADDI_T4, S_ALU_T5,
        S_LD_T3, S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7,
        S_ST_T6, S_ST_T7,
        S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6,
        S_JR_T3, S_IN_T3, S_OUT_T3, S_MFHI_T3, S_MFLO_T3,
        S_MD_T3, S_MD_T4, S_MD_T5, S_MD_T6,
        S_HALT
    } state_t;

    // All single-bit control outputs
    typedef struct packed {
        logic hi_in, lo_in, pc_in, mdr_in, z_in, y_in, mar_in, ir_in, con_in, outport_in;
        logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, y_out, c_out;
        logic gra, grb, grc, r_in, r_out, ba_out;
        logic read, write, inc_pc;
        logic run;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the current FSM state (and CON in the branch
// step) into the control-signal bundle and the ALU operation code.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] op,
    input  logic       con,
    output ctrl_t      ctrl,
    output logic [4:0] alu_op
);

    // Moore decode: every signal defaults low, ALU defaults to ADD
    always_comb begin
        ctrl   = '0;
        alu_op = ALU_ADD;
        ctrl.run = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
            end
            S_T1: begin
                ctrl.zlo_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            S_ALU_T3: begin
                ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
            end
            S_ALU_T4: begin
                ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; alu_op = op;
            end
            S_ADDI_T4: begin
                ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
            end
            S_ALU_T5: begin
                ctrl.zlo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
            S_LD_T3: begin
                ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
            end
            S_LD_T4: begin
                ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
            end
            S_LD_T5: begin
                ctrl.zlo_out = 1'b1; ctrl.mar_in = 1'b1;
            end
            S_LD_T6: begin
                ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            S_LD_T7: begin
                ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
            S_ST_T6: begin
                ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
            end
            S_ST_T7: begin
                ctrl.write = 1'b1;
            end
            S_BR_T3: begin
                ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1;
            end
            S_BR_T4: begin
                ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
            end
            S_BR_T5: begin
                ctrl.c_out = 1'b1; ctrl.z_in = 1'b1;
            end
            S_BR_T6: begin
                // Branch target is committed only when the condition held
                ctrl.zlo_out = con; ctrl.pc_in = con;
            end
            S_JR_T3: begin
                ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1;
            end
            S_IN_T3: begin
                ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
            S_OUT_T3: begin
                ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.outport_in = 1'b1;
            end
            S_MFHI_T3: begin
                ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
            S_MFLO_T3: begin
                ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
            end
            S_MD_T3: begin
                ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
            end
            S_MD_T4: begin
                ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; alu_op = op;
            end
            S_MD_T5: begin
                ctrl.zlo_out = 1'b1; ctrl.lo_in = 1'b1;
            end
            S_MD_T6: begin
                ctrl.zhi_out = 1'b1; ctrl.hi_in = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: state register, latched opcode and next-state
// logic; output decode lives in ctrl_decode.
// Optional feature: define CTRL_MUL_DIV_EN to enable the mul/div execute
// sequence; otherwise opcodes 15 and 16 retire like nop.
module control_unit
    import ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
    output logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout,
    output logic        Read, write, IncPC,
    output logic [4:0]  ALUop,
    output logic        Run,
    output logic [4:0]  dbg_state
);

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;
    ctrl_t      ctrl;
    logic [4:0] ir_op;
    logic       unused_ir;

    assign ir_op     = IR[31:27];
    assign unused_ir = ^IR[26:0];

    // State and opcode registers; reset aborts any instruction at once
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_RESET;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state: dispatch on IR in T2, then sequence on the latched opcode
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2: begin
                op_d = ir_op;
                case (ir_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_d = S_ALU_T3;
                    OP_LD, OP_LDI, OP_ST:                   state_d = S_LD_T3;
                    OP_BR:   state_d = S_BR_T3;
                    OP_JR:   state_d = S_JR_T3;
                    OP_IN:   state_d = S_IN_T3;
                    OP_OUT:  state_d = S_OUT_T3;
                    OP_MFHI: state_d = S_MFHI_T3;
                    OP_MFLO: state_d = S_MFLO_T3;
                    OP_HALT: state_d = S_HALT;
`ifdef CTRL_MUL_DIV_EN
                    OP_MUL, OP_DIV: state_d = S_MD_T3;
`endif
                    default: state_d = S_T0;
                endcase
            end
            S_ALU_T3:  state_d = (op_q == OP_ADDI) ? S_ADDI_T4 : S_ALU_T4;
            S_ALU_T4:  state_d = S_ALU_T5;
            S_ADDI_T4: state_d = S_ALU_T5;
            S_ALU_T5:  state_d = S_T0;
            S_LD_T3:   state_d = S_LD_T4;
            S_LD_T4:   state_d = (op_q == OP_LDI) ? S_ALU_T5 : S_LD_T5;
            S_LD_T5:   state_d = (op_q == OP_ST) ? S_ST_T6 : S_LD_T6;
            S_LD_T6:   state_d = S_LD_T7;
            S_LD_T7:   state_d = S_T0;
            S_ST_T6:   state_d = S_ST_T7;
            S_ST_T7:   state_d = S_T0;
            S_BR_T3:   state_d = S_BR_T4;
            S_BR_T4:   state_d = S_BR_T5;
            S_BR_T5:   state_d = S_BR_T6;
            S_BR_T6:   state_d = S_T0;
            S_JR_T3, S_IN_T3, S_OUT_T3, S_MFHI_T3, S_MFLO_T3: state_d = S_T0;
            S_MD_T3:   state_d = S_MD_T4;
            S_MD_T4:   state_d = S_MD_T5;
            S_MD_T5:   state_d = S_MD_T6;
            S_MD_T6:   state_d = S_T0;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_RESET;
        endcase
    end

    ctrl_decode u_decode (
        .state  (state_q),
        .op     (op_q),
        .con    (CON),
        .ctrl   (ctrl),
        .alu_op (ALUop)
    );

    assign HIin      = ctrl.hi_in;
    assign LOin      = ctrl.lo_in;
    assign PCin      = ctrl.pc_in;
    assign MDRin     = ctrl.mdr_in;
    assign Zin       = ctrl.z_in;
    assign Yin       = ctrl.y_in;
    assign MARin     = ctrl.mar_in;
    assign IRin      = ctrl.ir_in;
    assign CONin     = ctrl.con_in;
    assign OUTPORTin = ctrl.outport_in;
    assign HIout     = ctrl.hi_out;
    assign LOout     = ctrl.lo_out;
    assign ZHIout    = ctrl.zhi_out;
    assign ZLOout    = ctrl.zlo_out;
    assign PCout     = ctrl.pc_out;
    assign MDRout    = ctrl.mdr_out;
    assign INPORTout = ctrl.inport_out;
    assign Yout      = ctrl.y_out;
    assign Cout      = ctrl.c_out;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign Rin       = ctrl.r_in;
    assign Rout      = ctrl.r_out;
    assign BAout     = ctrl.ba_out;
    assign Read      = ctrl.read;
    assign write     = ctrl.write;
    assign IncPC     = ctrl.inc_pc;
    assign Run       = ctrl.run;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks reset, several instruction
// classes, the branch condition, halt and a reset abort of a store.
module tb_control_unit;
  import ctrl_pkg::*;

  logic        Clock, Reset, CON;
  logic [31:0] IR;
  logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
  logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC, Run;
  logic [4:0] ALUop, dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  logic mon_en     = 1'b0;
  logic abort_win  = 1'b0;
  logic write_seen = 1'b0;

  // Bit positions of the observed control vector
  localparam logic [28:0] HI_IN   = 29'd1 << 28, LO_IN   = 29'd1 << 27, PC_IN   = 29'd1 << 26;
  localparam logic [28:0] MDR_IN  = 29'd1 << 25, Z_IN    = 29'd1 << 24, Y_IN    = 29'd1 << 23;
  localparam logic [28:0] MAR_IN  = 29'd1 << 22, IR_IN   = 29'd1 << 21, CON_IN  = 29'd1 << 20;
  localparam logic [28:0] OUTP_IN = 29'd1 << 19, HI_OUT  = 29'd1 << 18, LO_OUT  = 29'd1 << 17;
  localparam logic [28:0] ZHI_OUT = 29'd1 << 16, ZLO_OUT = 29'd1 << 15, PC_OUT  = 29'd1 << 14;
  localparam logic [28:0] MDR_OUT = 29'd1 << 13, INP_OUT = 29'd1 << 12;
  localparam logic [28:0] C_OUT   = 29'd1 << 10, GRA     = 29'd1 << 9,  GRB     = 29'd1 << 8;
  localparam logic [28:0] GRC     = 29'd1 << 7,  RIN     = 29'd1 << 6,  ROUT    = 29'd1 << 5;
  localparam logic [28:0] BA_OUT  = 29'd1 << 4,  READ    = 29'd1 << 3,  WRITE   = 29'd1 << 2;
  localparam logic [28:0] INC_PC  = 29'd1 << 1,  RUN     = 29'd1;
  localparam logic [28:0] NONE    = 29'd0;

  logic [28:0] got_cv;
  logic [10:0] drivers;
  assign got_cv = {HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
                   HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout,
                   Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC, Run};
  assign drivers = {HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout, Rout, BAout};

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .IRin(IRin), .CONin(CONin), .OUTPORTin(OUTPORTin),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .INPORTout(INPORTout), .Yout(Yout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Read(Read), .write(write), .IncPC(IncPC), .ALUop(ALUop), .Run(Run),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Mid-cycle invariants: single bus driver, no simultaneous read/write
  always @(negedge Clock) begin
    if (mon_en) begin
      n_assert++;
      assert ($countones(drivers) <= 1) else begin
        n_fail++;
        $error("FAIL bus_single_driver got=%b exp=at most one", drivers);
      end
      n_assert++;
      assert (!(Read && write)) else begin
        n_fail++;
        $error("FAIL read_write_excl got=%b%b exp=not both", Read, write);
      end
      if (abort_win && write) write_seen = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [28:0] exp_cv, input logic [4:0] exp_alu);
    n_assert++;
    assert (got_cv === exp_cv) else begin
      n_fail++;
      $error("FAIL %s ctrl got=%h exp=%h", tag, got_cv, exp_cv);
    end
    n_assert++;
    assert (ALUop === exp_alu) else begin
      n_fail++;
      $error("FAIL %s aluop got=%0d exp=%0d", tag, ALUop, exp_alu);
    end
  endtask

  task automatic chk_state(input string tag, input state_t exp_st);
    n_assert++;
    assert (dbg_state === exp_st) else begin
      n_fail++;
      $error("FAIL %s state got=%0d exp=%0d", tag, dbg_state, exp_st);
    end
  endtask

  task automatic step(input string tag, input logic [28:0] exp_cv, input logic [4:0] exp_alu);
    @(posedge Clock);
    #1;
    chk(tag, exp_cv, exp_alu);
  endtask

  // Fetch T0..T2; IR is applied once T0 is reached so the previous
  // instruction's dispatch is never disturbed.
  task automatic fetch(input string nm, input logic [31:0] ir);
    step({nm, "_t0"}, PC_OUT | MAR_IN | INC_PC | Z_IN | RUN, ALU_ADD);
    IR = ir;
    step({nm, "_t1"}, ZLO_OUT | PC_IN | READ | MDR_IN | RUN, ALU_ADD);
    step({nm, "_t2"}, MDR_OUT | IR_IN | RUN, ALU_ADD);
  endtask

  task automatic hold_reset(input string nm);
    Reset = 1'b1;
    #1;
    chk({nm, "_async"}, NONE, ALU_ADD);
    chk_state({nm, "_async"}, S_RESET);
    step({nm, "_held"}, NONE, ALU_ADD);
    Reset = 1'b0;
    chk({nm, "_released"}, NONE, ALU_ADD);
  endtask

  // Directed stimulus
  initial begin
    Reset = 1'b1;
    CON   = 1'b0;
    IR    = 32'h0;
    repeat (2) @(posedge Clock);
    #1;
    mon_en = 1'b1;
    chk("reset_hold", NONE, ALU_ADD);
    chk_state("reset_hold", S_RESET);
    Reset = 1'b0;
    chk("reset_release", NONE, ALU_ADD);

    // add R3,R1,R2
    fetch("add", 32'h19890000);
    step("add_t3", GRB | ROUT | Y_IN | RUN, ALU_ADD);
    step("add_t4", GRC | ROUT | Z_IN | RUN, 5'd3);
    step("add_t5", ZLO_OUT | GRA | RIN | RUN, ALU_ADD);

    // sub: ALUop follows the opcode in T4
    fetch("sub", 32'h20000000);
    step("sub_t3", GRB | ROUT | Y_IN | RUN, ALU_ADD);
    step("sub_t4", GRC | ROUT | Z_IN | RUN, 5'd4);
    step("sub_t5", ZLO_OUT | GRA | RIN | RUN, ALU_ADD);

    // mflo R6
    fetch("mflo", 32'hCB000000);
    step("mflo_t3", LO_OUT | GRA | RIN | RUN, ALU_ADD);

    // addi
    fetch("addi", 32'h60000000);
    step("addi_t3", GRB | ROUT | Y_IN | RUN, ALU_ADD);
    step("addi_t4", C_OUT | Z_IN | RUN, ALU_ADD);
    step("addi_t5", ZLO_OUT | GRA | RIN | RUN, ALU_ADD);

    // ldi
    fetch("ldi", 32'h08000000);
    step("ldi_t3", GRB | BA_OUT | Y_IN | RUN, ALU_ADD);
    step("ldi_t4", C_OUT | Z_IN | RUN, ALU_ADD);
    step("ldi_t5", ZLO_OUT | GRA | RIN | RUN, ALU_ADD);

    // ld
    fetch("ld", 32'h00000000);
    step("ld_t3", GRB | BA_OUT | Y_IN | RUN, ALU_ADD);
    step("ld_t4", C_OUT | Z_IN | RUN, ALU_ADD);
    step("ld_t5", ZLO_OUT | MAR_IN | RUN, ALU_ADD);
    step("ld_t6", READ | MDR_IN | RUN, ALU_ADD);
    step("ld_t7", MDR_OUT | GRA | RIN | RUN, ALU_ADD);

    // st, full run
    fetch("st", 32'h10000000);
    step("st_t3", GRB | BA_OUT | Y_IN | RUN, ALU_ADD);
    step("st_t4", C_OUT | Z_IN | RUN, ALU_ADD);
    step("st_t5", ZLO_OUT | MAR_IN | RUN, ALU_ADD);
    step("st_t6", GRA | ROUT | MDR_IN | RUN, ALU_ADD);
    step("st_t7", WRITE | RUN, ALU_ADD);

    // br R5 with CON=0, then CON=1
    CON = 1'b0;
    fetch("br0", 32'h92800000);
    step("br0_t3", GRA | ROUT | CON_IN | RUN, ALU_ADD);
    step("br0_t4", PC_OUT | Y_IN | RUN, ALU_ADD);
    step("br0_t5", C_OUT | Z_IN | RUN, ALU_ADD);
    step("br0_t6", RUN, ALU_ADD);
    CON = 1'b1;
    fetch("br1", 32'h92800000);
    step("br1_t3", GRA | ROUT | CON_IN | RUN, ALU_ADD);
    step("br1_t4", PC_OUT | Y_IN | RUN, ALU_ADD);
    step("br1_t5", C_OUT | Z_IN | RUN, ALU_ADD);
    step("br1_t6", ZLO_OUT | PC_IN | RUN, ALU_ADD);
    CON = 1'b0;

    // single-step instructions
    fetch("jr", 32'h98000000);
    step("jr_t3", GRA | ROUT | PC_IN | RUN, ALU_ADD);
    fetch("in", 32'hB0000000);
    step("in_t3", INP_OUT | GRA | RIN | RUN, ALU_ADD);
    fetch("out", 32'hB8000000);
    step("out_t3", GRA | ROUT | OUTP_IN | RUN, ALU_ADD);
    fetch("mfhi", 32'hC0000000);
    step("mfhi_t3", HI_OUT | GRA | RIN | RUN, ALU_ADD);

    // nop and an undefined opcode retire straight from T2 (next fetch checks T0)
    fetch("nop", 32'hD0000000);
    fetch("undef7", 32'h38000000);

    // mul: full sequence only when the feature is built in
    fetch("mul", 32'h78000000);
`ifdef CTRL_MUL_DIV_EN
    step("mul_t3", GRA | ROUT | Y_IN | RUN, ALU_ADD);
    step("mul_t4", GRB | ROUT | Z_IN | RUN, 5'd15);
    step("mul_t5", ZLO_OUT | LO_IN | RUN, ALU_ADD);
    step("mul_t6", ZHI_OUT | HI_IN | RUN, ALU_ADD);
`endif

    // st aborted by reset in T6
    fetch("sta", 32'h10000000);
    step("sta_t3", GRB | BA_OUT | Y_IN | RUN, ALU_ADD);
    step("sta_t4", C_OUT | Z_IN | RUN, ALU_ADD);
    step("sta_t5", ZLO_OUT | MAR_IN | RUN, ALU_ADD);
    step("sta_t6", GRA | ROUT | MDR_IN | RUN, ALU_ADD);
    abort_win = 1'b1;
    hold_reset("sta_abort");
    fetch("post_abort", 32'hD8000000);
    abort_win = 1'b0;
    n_assert++;
    assert (write_seen === 1'b0) else begin
      n_fail++;
      $error("FAIL st_abort_write got=%b exp=0", write_seen);
    end

    // halt: static zero outputs for 20 cycles
    step("halt_enter", NONE, ALU_ADD);
    chk_state("halt_enter", S_HALT);
    for (int i = 0; i < 20; i++) step("halt_hold", NONE, ALU_ADD);
    chk_state("halt_hold", S_HALT);
    hold_reset("halt_reset");
    step("halt_exit_t0", PC_OUT | MAR_IN | INC_PC | Z_IN | RUN, ALU_ADD);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have no parameters; all encodings come from ctrl_pkg.
REQ-002 Clock  input  1  single system clock, all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high; forces RESET state.
REQ-004 IR  input  32  instruction register contents; opcode IR[31:27].
REQ-005 CON  input  1  branch-condition flag from datapath CON FF.
REQ-006 HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin  output  1 each  register load enables.
REQ-007 HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Yout, Cout  output  1 each  bus drive selects.
REQ-008 Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-file select/enable.
REQ-009 Read, write, IncPC  output  1 each  memory read, memory write, PC increment.
REQ-010 ALUop  output  5  ALU operation code; opcode during ALU step, ADD otherwise.
REQ-011 Run  output  1  high while executing, low in RESET and HALT.

Function
REQ-012 Outputs SHALL be Moore: decoded from the current state register (plus CON in BR_T6 only), one state per clock.
REQ-013 Fetch: T0 PCout MARin IncPC Zin; T1 ZLOout PCin Read MDRin; T2 MDRout IRin; T2 -> first execute step of decoded opcode.
REQ-014 Opcodes: ld 0, ldi 1, st 2, add 3, sub 4, and 5, or 6, addi 12, mul 15, div 16, br 18, jr 19, in 22, out 23, mfhi 24, mflo 25, nop 26, halt 27.
REQ-015 add/sub/and/or: T3 Grb Rout Yin; T4 Grc Rout Zin ALUop=opcode; T5 ZLOout Gra Rin; -> T0.
REQ-016 addi: T3 Grb Rout Yin; T4 Cout Zin ALUop=ADD; T5 ZLOout Gra Rin; -> T0.
REQ-017 ld: T3 Grb BAout Yin; T4 Cout Zin; T5 ZLOout MARin; T6 Read MDRin; T7 MDRout Gra Rin; -> T0.
REQ-018 ldi: T3 Grb BAout Yin; T4 Cout Zin; T5 ZLOout Gra Rin; -> T0.
REQ-019 st: T3-T5 as ld; T6 Gra Rout MDRin; T7 write; -> T0.
REQ-020 br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout Zin; T6 ZLOout and PCin only if CON=1; -> T0.
REQ-021 jr: T3 Gra Rout PCin. in: T3 INPORTout Gra Rin. out: T3 Gra Rout OUTPORTin. mfhi: T3 HIout Gra Rin. mflo: T3 LOout Gra Rin. All -> T0.
REQ-022 nop and any undefined opcode SHALL go T2 -> T0 with no execute step.
REQ-023 halt: T2 -> HALT; HALT holds all outputs 0 and Run=0 until Reset.
REQ-024 At most one bus driver (*out, Rout, BAout) SHALL be asserted in any state.
REQ-025 write and Read SHALL never be asserted together.

Reset
REQ-026 Reset asserted: state=RESET immediately, every output 0, ALUop=ADD.
REQ-027 After Reset deasserts, RESET -> T0 on next rising edge, Run=1 from T0.
REQ-028 Reset mid-instruction SHALL abort with no further Rin/write/PCin pulse.

Configuration
REQ-029 Macro CTRL_MUL_DIV_EN: when defined, mul/div execute T3 Gra Rout Yin; T4 Grb Rout Zin ALUop=opcode; T5 ZLOout LOin; T6 ZHIout HIin; -> T0.
REQ-030 Without CTRL_MUL_DIV_EN, opcodes 15 and 16 SHALL behave as nop.

Structure
REQ-031 ctrl_pkg SHALL hold opcode constants, ALUop constants, and the state enumeration.
REQ-032 One sub-module ctrl_decode (combinational state/CON -> control outputs) SHALL be used; control_unit holds state register and next-state logic.

Verification
REQ-033 Reset high 2 cycles, release -> RESET, then T0 with PCout=MARin=IncPC=Zin=1, Run=1.
REQ-034 IR=0x19890000 (add R3,R1,R2) -> T3 Grb Rout Yin; T4 Grc Rout Zin ALUop=3; T5 ZLOout Gra Rin; then T0.
REQ-035 IR=0xCB000000 (mflo R6) -> T3 LOout Gra Rin only; next cycle T0.
REQ-036 IR=0x92800000 (br R5), CON=0 then CON=1 -> T6 PCin=0 first run, PCin=ZLOout=1 second run.
REQ-037 IR=0xD8000000 (halt) -> HALT, Run=0, outputs static for 20 cycles; Reset returns to T0.
REQ-038 Reset asserted during st T6 -> all outputs 0 that cycle, write never pulses.
